// File: rtl/if_id_pkg.sv
// +-----------------------------------------------------------------------+
// | if_id_pkg : shared widths, bubble encoding and entry layout for IF/ID  |
// | Revision  : 1.0                                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

package if_id_pkg;

  localparam int INSTR_W_D = 32;
  localparam int PC_W_D    = 8;
  localparam int PC_INC_D  = 4;
  localparam logic [INSTR_W_D-1:0] NOP_INSTR_D = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W_D-1:0] instr;
    logic [PC_W_D-1:0]    pc;
    logic [PC_W_D-1:0]    pc_plus;
  } if_id_entry_t;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// +-----------------------------------------------------------------------+
// | pipe_slot : one register entry with valid bit, load/clear/hold control |
// | Revision  : 1.0                                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

module pipe_slot
  import if_id_pkg::*;
#(
  parameter int               WIDTH     = INSTR_W_D + 2 * PC_W_D,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_q
);

  logic             r_valid;
  logic [WIDTH-1:0] r_q;

  // Clear drops only the valid bit; the payload keeps its last value.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_q     <= RESET_VAL;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_q     <= i_d;
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_q;

endmodule

`default_nettype wire

// File: rtl/if_id_skid_reg.sv
// +-----------------------------------------------------------------------+
// | if_id_skid_reg : IF/ID register with valid/ready and a one-entry skid  |
// | Revision       : 1.0                                                   |
// +-----------------------------------------------------------------------+
`default_nettype none

module if_id_skid_reg
  import if_id_pkg::*;
#(
  parameter int                 INSTR_W   = INSTR_W_D,
  parameter int                 PC_W      = PC_W_D,
  parameter int                 PC_INC    = PC_INC_D,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_D)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_plus_out,
  output logic               stalled
);

  localparam int c_ENTRY_W = INSTR_W + 2 * PC_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus;
  } entry_t;

  logic                 w_main_valid;
  logic                 w_skid_valid;
  logic [c_ENTRY_W-1:0] w_main_q;
  logic [c_ENTRY_W-1:0] w_skid_q;
  logic [c_ENTRY_W-1:0] w_main_d;
  entry_t               w_main;
  entry_t               w_in_entry;
  logic                 w_accept;
  logic                 w_fire;
  logic                 w_main_load;
  logic                 w_main_clear;
  logic                 w_skid_load;
  logic                 w_skid_clear;

  assign w_in_entry = {instr_in, pc_in, pc_in + PC_W'(PC_INC)};

  // in_ready comes straight from the skid valid flop, so ready never
  // depends combinationally on out_ready or in_valid.
  assign w_accept = in_valid & ~w_skid_valid;
  assign w_fire   = w_main_valid & out_ready;

  // A full skid refills main on fire, keeping strict FIFO order.
  assign w_main_load  = ~flush & ((w_accept & (~w_main_valid | w_fire)) | (w_skid_valid & w_fire));
  assign w_main_clear = flush | (~w_skid_valid & w_fire & ~w_accept);
  assign w_main_d     = w_skid_valid ? w_skid_q : c_ENTRY_W'(w_in_entry);
  assign w_skid_load  = ~flush & w_accept & w_main_valid & ~w_fire;
  assign w_skid_clear = flush | (w_skid_valid & w_fire);

  pipe_slot #(.WIDTH(c_ENTRY_W), .RESET_VAL('0)) u_main_slot (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_d     (w_main_d),
    .o_valid (w_main_valid),
    .o_q     (w_main_q)
  );

  pipe_slot #(.WIDTH(c_ENTRY_W), .RESET_VAL('0)) u_skid_slot (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_d     (c_ENTRY_W'(w_in_entry)),
    .o_valid (w_skid_valid),
    .o_q     (w_skid_q)
  );

  assign w_main      = w_main_q;
  assign out_valid   = w_main_valid;
  assign instr_out   = w_main_valid ? w_main.instr : NOP_INSTR;
  assign pc_out      = w_main.pc;
  assign pc_plus_out = w_main.pc_plus;
  assign in_ready    = ~w_skid_valid;
  assign stalled     = w_skid_valid;

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
// +-----------------------------------------------------------------------+
// | tb_if_id_skid_reg : scoreboard bench for the IF/ID skid register       |
// | Revision          : 1.0                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_if_id_skid_reg;
  import if_id_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr_in;
  logic [7:0]  pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic [7:0]  pc_out;
  logic [7:0]  pc_plus_out;
  logic        stalled;

  logic        v16_in_valid;
  logic        v16_in_ready;
  logic [31:0] v16_instr_in;
  logic [15:0] v16_pc_in;
  logic        v16_out_valid;
  logic [31:0] v16_instr_out;
  logic [15:0] v16_pc_out;
  logic [15:0] v16_pc_plus_out;
  logic        v16_stalled;

  int checks = 0;
  int errors = 0;

  if_id_entry_t sb[$];
  if_id_entry_t exp_e;
  if_id_entry_t push_e;
  logic [7:0]   pc_hold = 8'h00;

  always #5 clock = ~clock;

  if_id_skid_reg dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr_in    (instr_in),
    .pc_in       (pc_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .pc_plus_out (pc_plus_out),
    .stalled     (stalled)
  );

  if_id_skid_reg #(.PC_W(16)) dut16 (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (1'b0),
    .in_valid    (v16_in_valid),
    .in_ready    (v16_in_ready),
    .instr_in    (v16_instr_in),
    .pc_in       (v16_pc_in),
    .out_valid   (v16_out_valid),
    .out_ready   (1'b1),
    .instr_out   (v16_instr_out),
    .pc_out      (v16_pc_out),
    .pc_plus_out (v16_pc_plus_out),
    .stalled     (v16_stalled)
  );

  // Scoreboard: pushes on accept, pops on fire, mirrors occupancy flags.
  always @(negedge clock) begin
    if (!reset_n) begin
      sb.delete();
      pc_hold = 8'h00;
    end else begin
      checks++;
      if (in_ready !== (sb.size() < 2) || out_valid !== (sb.size() > 0)) begin
        errors++;
        $display("FAIL sb_flags: in_ready=%b out_valid=%b, required in_ready=%b out_valid=%b",
                 in_ready, out_valid, sb.size() < 2, sb.size() > 0);
      end
      checks++;
      if (pc_out !== ((sb.size() > 0) ? sb[0].pc : pc_hold)) begin
        errors++;
        $display("FAIL sb_pc: pc_out=%h, required %h", pc_out,
                 (sb.size() > 0) ? sb[0].pc : pc_hold);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_fire: instr_out=%h, required no output", instr_out);
        end else begin
          exp_e = sb.pop_front();
          if ({instr_out, pc_out, pc_plus_out} !== exp_e) begin
            errors++;
            $display("FAIL sb_fire: got %h/%h/%h, required %h/%h/%h",
                     instr_out, pc_out, pc_plus_out, exp_e.instr, exp_e.pc, exp_e.pc_plus);
          end
        end
      end
      if (sb.size() > 0) pc_hold = sb[0].pc;
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        push_e.instr   = instr_in;
        push_e.pc      = pc_in;
        push_e.pc_plus = pc_in + 8'd4;
        sb.push_back(push_e);
        if (sb.size() == 1) pc_hold = push_e.pc;
      end
      if (flush) sb.delete();
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; instr_in = 32'h55; pc_in = 8'h10;
    v16_in_valid = 1'b0; v16_instr_in = '0; v16_pc_in = '0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || instr_out !== 32'h0 || in_ready !== 1'b1 ||
        pc_plus_out !== 8'h00 || stalled !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ov=%b instr=%h ir=%b pcp=%h st=%b, required 0/0/1/00/0",
               out_valid, instr_out, in_ready, pc_plus_out, stalled);
    end
    reset_n = 1'b1; in_valid = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; instr_in = 32'hA + i; pc_in = 8'h20 + 8'(4 * i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || instr_out !== 32'hA + i ||
          pc_plus_out !== 8'h24 + 8'(4 * i) || stalled !== 1'b0) begin
        errors++;
        $display("FAIL stream_%0d: ov=%b instr=%h pcp=%h st=%b, required 1/%h/%h/0",
                 i, out_valid, instr_out, pc_plus_out, stalled, 32'hA + i, 8'h24 + 8'(4 * i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || instr_out !== 32'h0 || pc_out !== 8'h28 || pc_plus_out !== 8'h2C) begin
      errors++;
      $display("FAIL stream_drain: ov=%b instr=%h pc=%h pcp=%h, required 0/0/28/2c",
               out_valid, instr_out, pc_out, pc_plus_out);
    end
  endtask

  task automatic load_two(input logic [7:0] base);
    out_ready = 1'b0;
    in_valid = 1'b1; instr_in = 32'hA; pc_in = base;
    tick();
    instr_in = 32'hB; pc_in = base + 8'd4;
    tick();
  endtask

  task automatic test_back_pressure();
    load_two(8'h40);
    instr_in = 32'hEE; pc_in = 8'h99;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (instr_out !== 32'hA || stalled !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: instr=%h st=%b ir=%b ov=%b, required a/1/0/1",
                 i, instr_out, stalled, in_ready, out_valid);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (instr_out !== 32'hB || pc_out !== 8'h44 || stalled !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: instr=%h pc=%h st=%b ir=%b, required b/44/0/1",
               instr_out, pc_out, stalled, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    load_two(8'h50);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || instr_out !== 32'h0 || in_ready !== 1'b1 ||
        stalled !== 1'b0 || pc_out !== 8'h50) begin
      errors++;
      $display("FAIL flush_state: ov=%b instr=%h ir=%b st=%b pc=%h, required 0/0/1/0/50",
               out_valid, instr_out, in_ready, stalled, pc_out);
    end
    out_ready = 1'b1; in_valid = 1'b1; instr_in = 32'hD; pc_in = 8'h60;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || instr_out !== 32'hD || pc_plus_out !== 8'h64) begin
      errors++;
      $display("FAIL flush_next: ov=%b instr=%h pcp=%h, required 1/d/64", out_valid, instr_out, pc_plus_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_sole: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1; in_valid = 1'b1; instr_in = 32'h77; pc_in = 8'hFC;
    v16_in_valid = 1'b1; v16_instr_in = 32'h88; v16_pc_in = 16'hFFFE;
    tick();
    in_valid = 1'b0; v16_in_valid = 1'b0;
    checks++;
    if (pc_plus_out !== 8'h00 || pc_out !== 8'hFC) begin
      errors++;
      $display("FAIL wrap8: pc=%h pcp=%h, required fc/00", pc_out, pc_plus_out);
    end
    checks++;
    if (v16_out_valid !== 1'b1 || v16_pc_plus_out !== 16'h0002 || v16_pc_out !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap16: ov=%b pc=%h pcp=%h, required 1/fffe/0002",
               v16_out_valid, v16_pc_out, v16_pc_plus_out);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    load_two(8'h70);
    in_valid = 1'b0; reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || instr_out !== 32'h0 || pc_out !== 8'h00 || pc_plus_out !== 8'h00 ||
        in_ready !== 1'b1 || stalled !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ov=%b instr=%h pc=%h pcp=%h ir=%b st=%b, required 0/0/00/00/1/0",
               out_valid, instr_out, pc_out, pc_plus_out, in_ready, stalled);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_nofire_%0d: out_valid=%b instr=%h, required 0", i, out_valid, instr_out);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_wrap();
    test_reset_mid_stall();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
Parametrised IF/ID pipeline register with a valid/ready handshake on both sides and a one-entry skid buffer. Throughput is one instruction per cycle under back-pressure, with no combinational path from out_ready to in_ready. It captures the fetched instruction and PC, computes PC + PC_INC, and supports a pipeline flush that turns the stage into a bubble. It sits between the fetch unit and the decode stage.

Parameters:
INSTR_W, 32, instruction width in bits
PC_W, 8, PC width in bits
PC_INC, 4, increment added to the captured PC
NOP_INSTR, 32'h0000_0000, instruction value presented when the stage holds a bubble (width INSTR_W)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous reset, active-low
flush  in  1  discard all held entries this cycle
in_valid  in  1  fetch presents instr_in/pc_in
in_ready  out  1  stage can accept; registered, equals !skid_valid
instr_in  in  INSTR_W  fetched instruction
pc_in  in  PC_W  address of instr_in
out_valid  out  1  decode-side entry valid
out_ready  in  1  decode accepts this cycle
instr_out  out  INSTR_W  held instruction, or NOP_INSTR when empty
pc_out  out  PC_W  held PC
pc_plus_out  out  PC_W  held PC + PC_INC
stalled  out  1  skid entry occupied (back-pressure active)

Behaviour:
- Interface: single clock; reset is synchronous and active-low on reset_n, sampled at the rising edge of clock.
- Reset values: out_valid=0, instr_out=NOP_INSTR, pc_out=0, pc_plus_out=0, skid_valid=0, in_ready=1, stalled=0.
- Priority order: reset_n low, then flush, then normal operation.
- Handshake definitions:
  - accept = in_valid & in_ready.
  - fire = out_valid & out_ready.
  - Payload may change only when accept or fire occurs; otherwise all outputs hold.
- Captured entry: {instr_in, pc_in, pc_in + PC_INC}. The sum is truncated to PC_W bits, so it wraps (8'hFC + 4 = 8'h00).
- Normal update, skid empty:
  - accept and (!out_valid or fire): main <= input; out_valid=1.
  - accept, out_valid and !fire: skid <= input; skid_valid=1; in_ready goes to 0 next cycle.
  - !accept and fire: out_valid=0; instr_out <= NOP_INSTR; pc outputs hold.
- Normal update, skid full (in_ready=0, so no accept):
  - fire: main <= skid; skid_valid=0; in_ready goes to 1.
  - !fire: hold everything.
- Latency: one cycle from accept to out_valid when the stage is empty. Order is strictly FIFO: the skid entry never overtakes main.
- Flush: main and skid are invalidated next cycle. out_valid=0, instr_out=NOP_INSTR, in_ready=1, stalled=0. Any accept or fire in the flush cycle is treated as completed and its data discarded. pc_out and pc_plus_out hold their previous values.
- Reset mid-operation: all held entries are dropped, and no fire is reported after reset.
- stalled mirrors skid_valid, registered.
- No combinational path from out_ready or in_valid to in_ready.

Decomposition:
- Package if_id_pkg holds:
  - default widths INSTR_W_D=32 and PC_W_D=8,
  - PC_INC_D=4,
  - NOP_INSTR_D,
  - packed struct if_id_entry_t {instr, pc, pc_plus}.
- One sub-module, pipe_slot: a single register entry with a valid bit, load, clear and hold controls, and synchronous active-low reset. It is instantiated twice, as the main slot and the skid slot. The top level contains only the handshake control and the PC adder.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> out_valid=0, instr_out=0, in_ready=1, pc_plus_out=0. Release reset -> in_ready=1.
- Streaming: out_ready=1; feed pc_in=0x20,0x24,0x28 with instr 0xA,0xB,0xC, one per cycle -> one cycle later out shows 0xA/pc_plus 0x24, then 0xB/0x28, then 0xC/0x2C; stalled stays 0.
- Back-pressure: out_ready=0 while sending 0xA then 0xB -> out holds 0xA, stalled=1, in_ready=0. Raise out_ready -> 0xA fires, then 0xB, with no loss or duplication.
- Flush with skid full: main=0xA, skid=0xB, pulse flush -> next cycle out_valid=0, instr_out=NOP_INSTR, in_ready=1. The next accepted instruction 0xD appears as the sole output.
- Wrap: pc_in=8'hFC -> pc_plus_out=8'h00, pc_out=8'hFC. With PC_W=16, pc_in=16'hFFFE -> pc_plus_out=16'h0002.
- Reset mid-stall: skid full, pull reset_n low for one cycle -> all reset values next cycle, and neither 0xA nor 0xB ever fires afterwards.
